// File: rtl/ann_pkg.sv
// Shared types and helpers for the accuracy scoring stage.
package ann_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CAPT   = 3'd1,
    MULT   = 3'd2,
    DIV    = 3'd3,
    REPORT = 3'd4
  } tracker_state_t;

  // Accuracy is expressed in integer percent.
  localparam int PCT_SCALE = 100;

  // Index of the set bit of a one-hot vector (highest set bit wins if not one-hot).
  function automatic int unsigned onehot_to_idx(input logic [63:0] vec);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (vec[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/accuracy_tracker_if.sv
// Bundle of the scoring stage's sample input, class read port and status outputs.
interface accuracy_tracker_if #(
  parameter int NUM_CLASSES = 10,
  parameter int CNT_W       = 8,
  parameter int ACC_W       = 9,
  parameter int SEL_W       = $clog2(NUM_CLASSES)
);
  logic                   final_done;
  logic [NUM_CLASSES-1:0] final_out;
  logic [NUM_CLASSES-1:0] expected;
  logic [SEL_W-1:0]       class_sel;
  logic [CNT_W-1:0]       class_hits;
  logic [CNT_W-1:0]       correct_count;
  logic [CNT_W-1:0]       total_count;
  logic [ACC_W-1:0]       accuracy;
  logic                   accuracy_valid;
  logic                   begin_next;
  logic                   busy;
  logic                   run_done;
  logic                   overrun;

  // Producer side: the inference datapath / loader driving samples in.
  modport master (
    output final_done, final_out, expected, class_sel,
    input  class_hits, correct_count, total_count, accuracy,
    input  accuracy_valid, begin_next, busy, run_done, overrun
  );

  // Tracker side.
  modport slave (
    input  final_done, final_out, expected, class_sel,
    output class_hits, correct_count, total_count, accuracy,
    output accuracy_valid, begin_next, busy, run_done, overrun
  );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first.
// done_o is high during the cycle whose closing edge retires the last bit,
// so quotient_o holds the final result from the following cycle on.
module seq_divider #(
  parameter int DIV_W = 15
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [DIV_W-1:0] dividend_i,
  input  logic [DIV_W-1:0] divisor_i,
  output logic             done_o,
  output logic [DIV_W-1:0] quotient_o,
  output logic [DIV_W-1:0] remainder_o
);
  localparam int CW = $clog2(DIV_W + 1);

  logic             active_q;
  logic [CW-1:0]    cnt_q;
  logic [DIV_W-1:0] dq_q, dq_d;
  logic [DIV_W:0]   rem_q, rem_d;
  logic [DIV_W-1:0] dvs_q;
  logic [DIV_W:0]   rem_sh;
  logic             q_bit;

  // One restoring step; a zero divisor yields quotient bits of 0.
  always_comb begin
    rem_sh = {rem_q[DIV_W-1:0], dq_q[DIV_W-1]};
    q_bit  = (dvs_q != '0) && (rem_sh >= {1'b0, dvs_q});
    rem_d  = q_bit ? (rem_sh - {1'b0, dvs_q}) : rem_sh;
    dq_d   = {dq_q[DIV_W-2:0], q_bit};
  end

  // Iteration control: load on start, count down DIV_W steps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
    end else if (start_i && !active_q) begin
      active_q <= 1'b1;
      cnt_q    <= CW'(DIV_W);
    end else if (active_q) begin
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) active_q <= 1'b0;
    end
  end

  // Operand/partial-result registers; dividend shifts out as quotient shifts in.
  always_ff @(posedge clk) begin
    if (start_i && !active_q) begin
      dq_q  <= dividend_i;
      rem_q <= '0;
      dvs_q <= divisor_i;
    end else if (active_q) begin
      dq_q  <= dq_d;
      rem_q <= rem_d;
    end
  end

  assign done_o      = active_q && (cnt_q == CW'(1));
  assign quotient_o  = dq_q;
  assign remainder_o = rem_q[DIV_W-1:0];

endmodule

// File: rtl/accuracy_tracker.sv
// Scores each network decision against its label, keeps running and per-class
// counts, and reports integer accuracy before releasing the next sample.
module accuracy_tracker
  import ann_pkg::*;
#(
  parameter int NUM_CLASSES = 10,
  parameter int MAX_INPUTS  = 200,
  parameter int ACC_W       = 9,
  parameter int CNT_W       = $clog2(MAX_INPUTS + 1),
  parameter int DIV_W       = $clog2(MAX_INPUTS * 100 + 1)
) (
  input logic               clk,
  input logic               rst_vals_n,
  accuracy_tracker_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_CLASSES);

  tracker_state_t         state_q, state_d;
  logic [NUM_CLASSES-1:0] out_q, exp_q;
  logic [CNT_W-1:0]       total_q, correct_q;
  logic [CNT_W-1:0]       hits_q [NUM_CLASSES];
  logic [ACC_W-1:0]       acc_q;
  logic                   vld_q, run_done_q, overrun_q;
  logic                   accept, match;
  logic [SEL_W-1:0]       exp_idx;
  logic                   div_start, div_done;
  logic [DIV_W-1:0]       dividend, divisor, quot, rem;
  logic                   unused_div_bits;

  assign accept    = bus.final_done && !run_done_q && (state_q == IDLE);
  assign match     = (out_q == exp_q) && $onehot(exp_q);
  assign exp_idx   = SEL_W'(onehot_to_idx(64'(exp_q)));
  assign div_start = (state_q == MULT);
  assign dividend  = DIV_W'(correct_q) * DIV_W'(PCT_SCALE);
  assign divisor   = DIV_W'(total_q);
  assign unused_div_bits = ^{quot[DIV_W-1:ACC_W], rem};

  seq_divider #(.DIV_W(DIV_W)) u_div (
    .clk         (clk),
    .rst_n       (rst_vals_n),
    .start_i     (div_start),
    .dividend_i  (dividend),
    .divisor_i   (divisor),
    .done_o      (div_done),
    .quotient_o  (quot),
    .remainder_o (rem)
  );

  // Sequence one sample through capture, scaling, divide and report.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CAPT;
      CAPT:    state_d = MULT;
      MULT:    state_d = DIV;
      DIV:     if (div_done) state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state, counters, result and sticky flags.
  always_ff @(posedge clk) begin
    if (!rst_vals_n) begin
      state_q    <= IDLE;
      total_q    <= '0;
      correct_q  <= '0;
      for (int i = 0; i < NUM_CLASSES; i++) hits_q[i] <= '0;
      acc_q      <= '0;
      vld_q      <= 1'b0;
      run_done_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= (state_q == REPORT);
      if (bus.final_done && (state_q != IDLE)) overrun_q <= 1'b1;
      if (state_q == CAPT) begin
        if (total_q != CNT_W'(MAX_INPUTS)) total_q <= total_q + CNT_W'(1);
        if (match) begin
          if (correct_q != CNT_W'(MAX_INPUTS)) correct_q <= correct_q + CNT_W'(1);
          if (hits_q[exp_idx] != CNT_W'(MAX_INPUTS))
            hits_q[exp_idx] <= hits_q[exp_idx] + CNT_W'(1);
        end
      end
      if (state_q == REPORT) begin
        acc_q <= quot[ACC_W-1:0];
        if (total_q == CNT_W'(MAX_INPUTS)) run_done_q <= 1'b1;
      end
    end
  end

  // Sample capture; plain data, only meaningful once CAPT follows.
  always_ff @(posedge clk) begin
    if (accept) begin
      out_q <= bus.final_out;
      exp_q <= bus.expected;
    end
  end

  // Per-class hit read port; out-of-range selects read as zero.
  always_comb begin
    bus.class_hits = '0;
    if (int'(bus.class_sel) < NUM_CLASSES) bus.class_hits = hits_q[bus.class_sel];
  end

  assign bus.correct_count  = correct_q;
  assign bus.total_count    = total_q;
  assign bus.accuracy       = acc_q;
  assign bus.accuracy_valid = vld_q;
  assign bus.begin_next     = vld_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.run_done       = run_done_q;
  assign bus.overrun        = overrun_q;

endmodule

// File: tb/tb_accuracy_tracker.sv
// Bench for accuracy_tracker: behavioural score model plus directed and random samples.
module tb_accuracy_tracker;
  localparam int NC   = 10;
  localparam int MAXI = 200;
  localparam int CW   = 8;
  localparam int AW   = 9;
  localparam int DW   = 15;
  localparam int LAT  = DW + 3;

  logic clk = 1'b0;
  logic rst_vals_n = 1'b0;

  accuracy_tracker_if #(.NUM_CLASSES(NC), .CNT_W(CW), .ACC_W(AW)) bus ();

  accuracy_tracker #(.NUM_CLASSES(NC), .MAX_INPUTS(MAXI), .ACC_W(AW)) dut (
    .clk        (clk),
    .rst_vals_n (rst_vals_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      if (fails <= 25) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a sample accepted at edge T is counted at T+1 and
  // reported (accuracy, begin_next) at T+LAT; busy spans edges T..T+LAT-1.
  int ecnt = 0;
  bit m_active = 0;
  int m_t0 = 0;
  bit m_hit = 0;
  int m_idx = 0;
  int m_total = 0, m_correct = 0, m_acc = 0;
  bit m_run_done = 0, m_overrun = 0;
  int m_hits [NC];
  int m_pulse_edge = -1;
  int pulses = 0;
  bit chk_en = 0;

  initial for (int i = 0; i < NC; i++) m_hits[i] = 0;

  always @(posedge clk) begin
    ecnt++;
    if (!rst_vals_n) begin
      m_active = 0; m_total = 0; m_correct = 0; m_acc = 0;
      m_run_done = 0; m_overrun = 0; m_pulse_edge = -1;
      for (int i = 0; i < NC; i++) m_hits[i] = 0;
    end else begin
      if (bus.final_done) begin
        if (m_active) m_overrun = 1;
        else if (!m_run_done) begin
          m_active = 1;
          m_t0 = ecnt;
          m_hit = (bus.final_out == bus.expected) && ($countones(bus.expected) == 1);
          m_idx = 0;
          for (int i = 0; i < NC; i++) if (bus.expected[i]) m_idx = i;
        end
      end
      if (m_active && ecnt == m_t0 + 1) begin
        m_total++;
        if (m_hit) begin m_correct++; m_hits[m_idx]++; end
      end
      if (m_active && ecnt == m_t0 + LAT) begin
        m_acc = (m_correct * 100) / m_total;
        if (m_total == MAXI) m_run_done = 1;
        m_pulse_edge = ecnt;
        m_active = 0;
      end
    end
  end

  // Compare process: every cycle, away from the rising edge.
  always @(negedge clk) begin
    int sel;
    sel = $urandom_range(0, 15);
    bus.class_sel = 4'(sel);
    #1;
    if (chk_en) begin
      chk("busy", bus.busy, m_active);
      chk("begin_next", bus.begin_next, (m_pulse_edge == ecnt));
      chk("accuracy_valid", bus.accuracy_valid, (m_pulse_edge == ecnt));
      chk("accuracy", bus.accuracy, m_acc);
      chk("correct_count", bus.correct_count, m_correct);
      chk("total_count", bus.total_count, m_total);
      chk("run_done", bus.run_done, m_run_done);
      chk("overrun", bus.overrun, m_overrun);
      chk("class_hits", bus.class_hits, (sel < NC) ? m_hits[sel] : 0);
      if (bus.begin_next) pulses++;
    end
  end

  task automatic send(input logic [NC-1:0] fo, input logic [NC-1:0] ex, output int t);
    @(negedge clk);
    bus.final_done = 1'b1;
    bus.final_out  = fo;
    bus.expected   = ex;
    @(negedge clk);
    t = ecnt;
    bus.final_done = 1'b0;
  endtask

  task automatic wait_pulse(output int t);
    t = -1;
    for (int i = 0; i < LAT + 10; i++) begin
      @(negedge clk);
      #2;
      if (bus.begin_next) begin t = ecnt; break; end
    end
    if (t < 0) chk("pulse_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_vals_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_vals_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t0, tp, p0;
    logic [NC-1:0] v, w;
    bus.final_done = 1'b0;
    bus.final_out  = '0;
    bus.expected   = '0;

    // Reset held two cycles, then released.
    repeat (2) @(negedge clk);
    chk_en = 1;
    #2;
    chk("rst_busy", bus.busy, 0);
    chk("rst_accuracy", bus.accuracy, 0);
    chk("rst_total", bus.total_count, 0);
    chk("rst_correct", bus.correct_count, 0);
    chk("rst_begin_next", bus.begin_next, 0);
    chk("rst_run_done", bus.run_done, 0);
    chk("rst_overrun", bus.overrun, 0);
    rst_vals_n = 1'b1;
    @(negedge clk); #2;
    chk("post_rst_total", bus.total_count, 0);
    chk("post_rst_accuracy", bus.accuracy, 0);

    // Single hit on class 3.
    send(10'b0000001000, 10'b0000001000, t0);
    wait_pulse(tp);
    chk("latency", tp - t0, 18);
    chk("hit_accuracy", bus.accuracy, 100);
    chk("hit_valid", bus.accuracy_valid, 1);
    chk("hit_total", bus.total_count, 1);
    chk("model_hits3", m_hits[3], 1);

    // Hit, miss, miss.
    do_reset();
    send(10'h010, 10'h010, t0); wait_pulse(tp);
    chk("mix1_acc", bus.accuracy, 100);
    send(10'h001, 10'h002, t0); wait_pulse(tp);
    chk("mix2_acc", bus.accuracy, 50);
    send(10'h004, 10'h100, t0); wait_pulse(tp);
    chk("mix3_acc", bus.accuracy, 33);
    chk("mix_correct", bus.correct_count, 1);
    chk("mix_total", bus.total_count, 3);

    // Non-one-hot decision equal to a non-one-hot label is a miss.
    do_reset();
    send(10'b0000000011, 10'b0000000011, t0); wait_pulse(tp);
    chk("nonhot_acc", bus.accuracy, 0);
    chk("nonhot_total", bus.total_count, 1);
    chk("nonhot_correct", bus.correct_count, 0);

    // Second sample two cycles after the first is dropped.
    do_reset();
    p0 = pulses;
    send(10'h020, 10'h020, t0);
    send(10'h040, 10'h040, tp);
    repeat (LAT + 5) @(negedge clk);
    #2;
    chk("ovr_flag", bus.overrun, 1);
    chk("ovr_total", bus.total_count, 1);
    chk("ovr_pulses", pulses - p0, 1);

    // Random samples with random gaps (some land while busy).
    do_reset();
    for (int n = 0; n < 60; n++) begin
      v = '0; v[$urandom_range(0, NC - 1)] = 1'b1;
      case ($urandom_range(0, 2))
        0: w = v;
        1: begin w = '0; w[$urandom_range(0, NC - 1)] = 1'b1; end
        default: w = NC'($urandom);
      endcase
      send(w, v, t0);
      repeat ($urandom_range(0, LAT + 4)) @(negedge clk);
    end
    repeat (LAT + 2) @(negedge clk);

    // Reset during the divide discards the result.
    do_reset();
    p0 = pulses;
    send(10'h080, 10'h080, t0);
    repeat (8) @(negedge clk);
    rst_vals_n = 1'b0;
    @(negedge clk);
    rst_vals_n = 1'b1;
    repeat (LAT + 5) @(negedge clk);
    #2;
    chk("midrst_pulses", pulses - p0, 0);
    chk("midrst_total", bus.total_count, 0);
    chk("midrst_busy", bus.busy, 0);

    // Full run of MAX_INPUTS hits, then one more that must be ignored.
    for (int n = 0; n < MAXI; n++) begin
      v = '0; v[$urandom_range(0, NC - 1)] = 1'b1;
      send(v, v, t0);
      wait_pulse(tp);
    end
    @(negedge clk); #2;
    chk("full_acc", bus.accuracy, 100);
    chk("full_total", bus.total_count, 200);
    chk("full_correct", bus.correct_count, 200);
    chk("full_run_done", bus.run_done, 1);
    p0 = pulses;
    send(10'h001, 10'h001, t0);
    repeat (LAT + 5) @(negedge clk);
    #2;
    chk("extra_pulses", pulses - p0, 0);
    chk("extra_total", bus.total_count, 200);
    chk("extra_overrun", bus.overrun, 0);
    chk("extra_busy", bus.busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
